demux_2_4_2: RTL and testbench

DEMUX_2_4_2 -- requirements
Module: demux_2_4_2

---
 rtl/demux_2_4_2.sv | 135 +++++++++++++
 tb/tb_demux_2_4_2.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/demux_2_4_2.sv
// demux_2_4_2: 1-to-4 demultiplexer built from four one-entry output buffers.
// A word on i is steered to channel `select` and held there until sink k takes it.
// Optional per-channel 8-bit accept counters are present when DEMUX_CNT_EN is defined.

// One output channel: a single-entry buffer (EMPTY / FULL) plus its optional counter.
module demux_2_4_2_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
`ifdef DEMUX_CNT_EN
  output logic [7:0]       cnt_o,
`endif
  output logic             vld_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  // A load always wins over a drain at the same edge, so the channel stays FULL
  // with the new word; data is kept when not loaded so EMPTY holds the last word.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q & ~drain_i;
    if (load_i) begin
      data_d = data_i;
      vld_d  = 1'b1;
    end
  end

  // Buffer state register; reset clears both the word and its valid flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign data_o = data_q;
  assign vld_o  = vld_q;

`ifdef DEMUX_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Count accepts into this channel; wraps naturally at 8 bits, drains ignored.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) cnt_d = cnt_q + 8'd1;
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
`endif

endmodule

module demux_2_4_2 #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] i,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [3:0]       o_valid,
`ifdef DEMUX_CNT_EN
  output logic [31:0]      cnt,
`endif
  input  logic [3:0]       o_ready
);

  localparam int NUM_CH = 4;

  logic [NUM_CH-1:0][WIDTH-1:0] data_w;
  logic [NUM_CH-1:0]            load;
  logic [NUM_CH-1:0]            drain;
  logic                         accept;
`ifdef DEMUX_CNT_EN
  logic [NUM_CH-1:0][7:0]       cnt_w;
`endif

  // The selected channel can take a word if it is empty or being drained this cycle.
  assign i_ready = ~o_valid[select] | o_ready[select];
  assign accept  = i_valid & i_ready;
  assign drain   = o_valid & o_ready;

  // One-hot load strobe towards the selected channel.
  always_comb begin
    load = '0;
    if (accept) load[select] = 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    demux_2_4_2_chan #(.WIDTH(WIDTH)) u_chan (
      .clock   (clock),
      .reset   (reset),
      .load_i  (load[g]),
      .drain_i (drain[g]),
      .data_i  (i),
      .data_o  (data_w[g]),
`ifdef DEMUX_CNT_EN
      .cnt_o   (cnt_w[g]),
`endif
      .vld_o   (o_valid[g])
    );
  end

  assign o0 = data_w[0];
  assign o1 = data_w[1];
  assign o2 = data_w[2];
  assign o3 = data_w[3];

`ifdef DEMUX_CNT_EN
  // Channel k lands in bits [8k+7:8k].
  assign cnt = cnt_w;
`endif

endmodule

// File: tb/tb_demux_2_4_2.sv
// Directed self-checking bench for demux_2_4_2 (WIDTH=8).
// Counter checks are compiled only when DEMUX_CNT_EN is defined.
module tb_demux_2_4_2;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] select;
  logic [7:0] i;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] o0, o1, o2, o3;
  logic [3:0] o_valid;
  logic [3:0] o_ready;
`ifdef DEMUX_CNT_EN
  logic [31:0] cnt;
`endif

  int nchk = 0;
  int nerr = 0;

  demux_2_4_2 #(.WIDTH(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .select  (select),
    .i       (i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o0      (o0),
    .o1      (o1),
    .o2      (o2),
    .o3      (o3),
    .o_valid (o_valid),
`ifdef DEMUX_CNT_EN
    .cnt     (cnt),
`endif
    .o_ready (o_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] out_of(input int k);
    case (k)
      0: return o0;
      1: return o1;
      2: return o2;
      default: return o3;
    endcase
  endfunction

  initial begin
    reset = 1'b1; select = 2'd0; i = 8'h00; i_valid = 1'b0; o_ready = 4'b0000;
    #1;
    chk("rst_vld", 32'(o_valid), 32'h0);
    chk("rst_o0", 32'(o0), 32'h0);
    chk("rst_o1", 32'(o1), 32'h0);
    chk("rst_o2", 32'(o2), 32'h0);
    chk("rst_o3", 32'(o3), 32'h0);
    chk("rst_irdy", 32'(i_ready), 32'h1);
`ifdef DEMUX_CNT_EN
    chk("rst_cnt", cnt, 32'h0);
`endif
    step(); step();
    reset = 1'b0;

    // Single accept into channel 2 with all sinks stalled.
    select = 2'd2; i = 8'hA5; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    #1;
    chk("a_o2", 32'(o2), 32'hA5);
    chk("a_vld", 32'(o_valid), 32'h4);
    chk("a_o0", 32'(o0), 32'h0);
    chk("a_o1", 32'(o1), 32'h0);
    chk("a_o3", 32'(o3), 32'h0);
    chk("a_irdy", 32'(i_ready), 32'h0);

    // Drain channel 2; data is retained while EMPTY.
    o_ready = 4'b0100;
    step();
    o_ready = 4'b0000;
    chk("d_vld", 32'(o_valid), 32'h0);
    chk("d_o2", 32'(o2), 32'hA5);

    // Backpressure on channel 1, then simultaneous drain + load.
    select = 2'd1; i = 8'h11; i_valid = 1'b1;
    step();
    chk("bp_fill", 32'(o_valid), 32'h2);
    i = 8'h22;
    for (int n = 0; n < 3; n++) begin
      #1;
      chk("bp_irdy", 32'(i_ready), 32'h0);
      step();
      chk("bp_o1", 32'(o1), 32'h11);
      chk("bp_vld", 32'(o_valid), 32'h2);
    end
    o_ready = 4'b0010;
    #1;
    chk("bp_irdy_up", 32'(i_ready), 32'h1);
    step();
    i_valid = 1'b0;
    chk("bp_o1_new", 32'(o1), 32'h22);
    chk("bp_vld_new", 32'(o_valid), 32'h2);
    step();
    o_ready = 4'b0000;
    chk("bp_empty", 32'(o_valid), 32'h0);

    // Fill 0 and 3, then drain both while loading 2.
    select = 2'd0; i = 8'hC0; i_valid = 1'b1;
    step();
    select = 2'd3; i = 8'hC3;
    step();
    chk("ind_fill", 32'(o_valid), 32'h9);
    o_ready = 4'b1001; select = 2'd2; i = 8'h5A;
    step();
    i_valid = 1'b0; o_ready = 4'b0000;
    chk("ind_vld", 32'(o_valid), 32'h4);
    chk("ind_o2", 32'(o2), 32'h5A);
    chk("ind_o0", 32'(o0), 32'hC0);
    o_ready = 4'b0100;
    step();

    // o_ready on empty channels and idle input change nothing.
    o_ready = 4'b1111; select = 2'd0; i = 8'hFF; i_valid = 1'b0;
    step();
    chk("idle_vld", 32'(o_valid), 32'h0);
    chk("idle_o0", 32'(o0), 32'hC0);

    // Back-to-back stream with all sinks ready.
    for (int k = 0; k < 5; k++) begin
      select = 2'(k % 4); i = 8'(k + 1); i_valid = 1'b1;
      #1;
      chk("str_irdy", 32'(i_ready), 32'h1);
      step();
      chk("str_data", 32'(out_of(k % 4)), 32'(k + 1));
      chk("str_vld", 32'(o_valid), 32'(1 << (k % 4)));
    end
    i_valid = 1'b0;
    step();
    chk("str_end", 32'(o_valid), 32'h0);

    // Asynchronous reset between edges with channel 0 FULL.
    o_ready = 4'b0000; select = 2'd0; i = 8'h77; i_valid = 1'b1;
    step();
    chk("ar_fill", 32'(o_valid), 32'h1);
    i = 8'h88;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_vld", 32'(o_valid), 32'h0);
    chk("ar_o0", 32'(o0), 32'h0);
    step();
    chk("ar_noacc_vld", 32'(o_valid), 32'h0);
    chk("ar_noacc_o0", 32'(o0), 32'h0);
    #2;
    reset = 1'b0;
    step();
    chk("ar_first_o0", 32'(o0), 32'h88);
    chk("ar_first_vld", 32'(o_valid), 32'h1);
    i_valid = 1'b0;

`ifdef DEMUX_CNT_EN
    // Counter wrap: 257 accepts into channel 3.
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    o_ready = 4'b1000; select = 2'd3; i = 8'h33; i_valid = 1'b1;
    for (int n = 0; n < 257; n++) step();
    i_valid = 1'b0;
    step();
    chk("cnt_wrap", cnt, 32'h0100_0000);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
